// File: rtl/uart_transmitter_if.sv
// Host-side bus of the UART transmitter: write strobe, data byte, acknowledge,
// and the status flags the host polls or takes interrupts from.
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  host_write;
    logic                  host_aknowledged;
    logic                  tx_busy;
    logic                  buf_full;
    logic                  host_interrupt;
    logic                  tx_overrun;

    // Handshake: host_write is a one-cycle strobe. It is accepted on a posedge
    // where the registered buf_full is 0. When buf_full is 1 the byte is dropped
    // and tx_overrun is set. Before writing again, the host waits for
    // host_interrupt, which signals that the buffer is empty.
    modport master (
        output data_in, host_write, host_aknowledged,
        input  tx_busy, buf_full, host_interrupt, tx_overrun
    );

    modport slave (
        input  data_in, host_write, host_aknowledged,
        output tx_busy, buf_full, host_interrupt, tx_overrun
    );
endinterface

// File: rtl/uart_transmitter.sv
// Oversampled UART transmitter with a one-deep holding buffer. Frame layout:
// start, DATA_WIDTH data bits LSB first, even parity, STOP_BITS stop bits.
module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 2
) (
    input  logic                overSampler,
    input  logic                reset,
    uart_transmitter_if.slave   bus,
    output logic                serial_out,
    output logic [2:0]          dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + STOP_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    state_e                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   parity_q, parity_d;
    logic                   serial_q, serial_d;
    logic                   buf_full_q, buf_full_d;
    logic                   irq_q, irq_d;
    logic                   overrun_q, overrun_d;
    logic                   tick_end;
    logic                   load;
    logic                   write_ok;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        parity_d   = parity_q;
        serial_d   = serial_q;
        buf_full_d = buf_full_q;
        irq_d      = irq_q;
        overrun_d  = overrun_q;
        load       = 1'b0;
        tick_end   = (tick_q == TICK_LAST);
        write_ok   = bus.host_write && !buf_full_q;

        if (state_q != IDLE) begin
            tick_d = tick_end ? '0 : tick_q + 1'b1;
        end

        // serial_d is the value of the bit being entered, so the registered
        // line changes exactly on bit boundaries.
        case (state_q)
            IDLE: begin
                if (buf_full_q) load = 1'b1;
            end
            START: begin
                if (tick_end) begin
                    state_d  = DATA;
                    bit_d    = '0;
                    serial_d = shift_q[0];
                end
            end
            DATA: begin
                if (tick_end) begin
                    if (bit_q == DATA_LAST) begin
                        state_d  = PARITY;
                        serial_d = parity_q;
                    end else begin
                        shift_d  = shift_q >> 1;
                        bit_d    = bit_q + 1'b1;
                        serial_d = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (tick_end) begin
                    state_d  = STOP;
                    bit_d    = '0;
                    serial_d = 1'b1;
                end
            end
            STOP: begin
                if (tick_end) begin
                    if (bit_q == STOP_LAST) begin
                        if (buf_full_q) load = 1'b1;
                        else            state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase

        if (load) begin
            state_d    = START;
            tick_d     = '0;
            bit_d      = '0;
            shift_d    = hold_q;
            parity_d   = ^hold_q;
            serial_d   = 1'b0;
            buf_full_d = 1'b0;
        end

        // Writes are judged on the registered buf_full, so a write on a
        // transfer edge is dropped even though the buffer empties there.
        if (bus.host_write) begin
            if (buf_full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d     = bus.data_in;
                buf_full_d = 1'b1;
            end
        end

        if (bus.host_aknowledged || write_ok) irq_d = 1'b0;
        if (load)                             irq_d = 1'b1;
    end

    always_ff @(posedge overSampler) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
            buf_full_q <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            parity_q   <= parity_d;
            serial_q   <= serial_d;
            buf_full_q <= buf_full_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
        end
    end

    assign serial_out         = serial_q;
    assign dbg_state_o        = state_q;
    assign bus.tx_busy        = (state_q != IDLE);
    assign bus.buf_full       = buf_full_q;
    assign bus.host_interrupt = irq_q;
    assign bus.tx_overrun     = overrun_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of bytes with hand-computed parity,
// plus hand-written sequences for back-to-back, overrun, reset and ack corners.
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial;
    logic [2:0] dbg_state;

    uart_transmitter_if #(.DATA_WIDTH(8)) bus ();

    uart_transmitter #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(16),
        .STOP_BITS (2)
    ) dut (
        .overSampler(clk),
        .reset      (rst_n),
        .bus        (bus.slave),
        .serial_out (serial),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t       vecs[8];
    int         n_vec = 0;
    int         n_err = 0;
    int         wr_cyc[3];
    logic [7:0] wr_dat[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        bus.data_in    = d;
        bus.host_write = 1'b1;
        step();
        bus.host_write = 1'b0;
    endtask

    task automatic clear_writes();
        for (int i = 0; i < 3; i++) begin
            wr_cyc[i] = -1;
            wr_dat[i] = 8'h00;
        end
    endtask

    // Called right after the edge the byte entered the buffer (or right after the
    // previous frame's last cycle); checks every cycle of the 12 bits.
    task automatic check_frame(input logic [7:0] d, input logic par);
        logic [11:0] fr;
        logic        got;
        logic        busy_ok;
        int          k;
        fr      = {2'b11, par, d, 1'b0};
        busy_ok = 1'b1;
        for (int b = 0; b < 12; b++) begin
            got = fr[b];
            for (int c = 0; c < 16; c++) begin
                k = b * 16 + c;
                for (int w = 0; w < 3; w++) begin
                    if (wr_cyc[w] == k) begin
                        bus.data_in    = wr_dat[w];
                        bus.host_write = 1'b1;
                    end
                end
                step();
                bus.host_write = 1'b0;
                if (serial !== fr[b]) got = serial;
                if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
            end
            chk($sformatf("frame_%02h_bit%0d", d, b), {31'b0, got}, {31'b0, fr[b]});
        end
        chk($sformatf("frame_%02h_busy", d), {31'b0, busy_ok}, 32'd1);
        clear_writes();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && bus.tx_busy; i++) step();
        chk("wait_idle", {31'b0, bus.tx_busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h3C, 1'b0};
        vecs[7] = '{8'h5A, 1'b0};
        clear_writes();

        bus.data_in          = 8'h00;
        bus.host_write       = 1'b0;
        bus.host_aknowledged = 1'b0;
        rst_n                = 1'b0;
        repeat (3) step();
        chk("rst_serial",   {31'b0, serial},             32'd1);
        chk("rst_busy",     {31'b0, bus.tx_busy},        32'd0);
        chk("rst_buf_full", {31'b0, bus.buf_full},       32'd0);
        chk("rst_irq",      {31'b0, bus.host_interrupt}, 32'd0);
        chk("rst_overrun",  {31'b0, bus.tx_overrun},     32'd0);
        chk("rst_state",    {29'b0, dbg_state},          32'd0);
        rst_n = 1'b1;
        step();

        // Single frames from idle
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data);
            chk($sformatf("vec%0d_buf_full", v), {31'b0, bus.buf_full}, 32'd1);
            chk($sformatf("vec%0d_idle_line", v), {31'b0, serial}, 32'd1);
            check_frame(vecs[v].data, vecs[v].par);
            step();
            chk($sformatf("vec%0d_idle_after", v), {31'b0, bus.tx_busy}, 32'd0);
            chk($sformatf("vec%0d_line_after", v), {31'b0, serial}, 32'd1);
        end

        // Interrupt rises on transfer, ack clears it on the next edge
        send(8'h07);
        chk("t2_irq_cleared_by_write", {31'b0, bus.host_interrupt}, 32'd0);
        step();
        chk("t2_irq_set",   {31'b0, bus.host_interrupt}, 32'd1);
        chk("t2_start_bit", {31'b0, serial},             32'd0);
        chk("t2_state",     {29'b0, dbg_state},          32'd1);
        bus.host_aknowledged = 1'b1;
        step();
        bus.host_aknowledged = 1'b0;
        chk("t2_irq_acked", {31'b0, bus.host_interrupt}, 32'd0);
        wait_idle();

        // Back-to-back frames with no idle gap
        send(8'h11);
        wr_cyc[0] = 30;
        wr_dat[0] = 8'h22;
        check_frame(8'h11, 1'b0);
        chk("t3_no_overrun", {31'b0, bus.tx_overrun}, 32'd0);
        check_frame(8'h22, 1'b0);
        step();
        chk("t3_idle_after", {31'b0, bus.tx_busy}, 32'd0);

        // Same-edge write dropped, accepted write, then write into a full buffer
        send(8'h11);
        wr_cyc[0] = 0;  wr_dat[0] = 8'h55;
        wr_cyc[1] = 20; wr_dat[1] = 8'h33;
        wr_cyc[2] = 40; wr_dat[2] = 8'h55;
        check_frame(8'h11, 1'b0);
        chk("t4_overrun_set", {31'b0, bus.tx_overrun}, 32'd1);
        check_frame(8'h33, 1'b0);
        step();
        chk("t4_no_third_frame", {31'b0, bus.tx_busy},  32'd0);
        chk("t4_buf_empty",      {31'b0, bus.buf_full}, 32'd0);
        repeat (50) step();
        chk("t4_overrun_sticky", {31'b0, bus.tx_overrun}, 32'd1);

        // Reset in the middle of data bit 3
        send(8'hA5);
        repeat (69) step();
        chk("t5_in_data",  {29'b0, dbg_state}, 32'd2);
        chk("t5_bit3_val", {31'b0, serial},    32'd0);
        rst_n = 1'b0;
        step();
        chk("t5_serial",   {31'b0, serial},             32'd1);
        chk("t5_busy",     {31'b0, bus.tx_busy},        32'd0);
        chk("t5_buf_full", {31'b0, bus.buf_full},       32'd0);
        chk("t5_irq",      {31'b0, bus.host_interrupt}, 32'd0);
        chk("t5_overrun",  {31'b0, bus.tx_overrun},     32'd0);
        rst_n = 1'b1;
        step();
        send(8'h3C);
        check_frame(8'h3C, 1'b0);
        step();
        chk("t5_idle_after", {31'b0, bus.tx_busy}, 32'd0);

        // Ack on the same edge as a transfer: the set wins
        send(8'h5A);
        bus.host_aknowledged = 1'b1;
        step();
        bus.host_aknowledged = 1'b0;
        chk("t6_irq_set_wins", {31'b0, bus.host_interrupt}, 32'd1);
        chk("t6_start_bit",    {31'b0, serial},             32'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
